// File: rtl/hist_stream_out.sv
// hist_stream_out: per-frame luminance histogram with valid/ready bin readout.
// Passive tap on the raster pixel stream. Each frame starting at (0,0) is binned
// into a 1R1W RAM, then streamed out bin by bin (clear-on-accept), and the
// windowed percentile bounds of the dumped frame are published.
// Ports:
//   clock, n_rst                 clock, asynchronous active-low reset
//   in_pixel/in_vcnt/in_hcnt     pixel value and raster position
//   out_valid/out_ready          bin stream handshake
//   out_bin/out_count/out_last   bin index, pixel count, last-bin flag
//   win_lo/win_hi/win_valid      window bounds and their update pulse
//   skip_count                   frames missed because a dump was in progress
module hist_stream_out #(
  parameter int BIT_WIDTH    = 8,
  parameter int IMAGE_HEIGHT = -1,
  parameter int IMAGE_WIDTH  = -1,
  parameter int FRAME_HEIGHT = -1,
  parameter int FRAME_WIDTH  = -1,
  parameter int WINDOW_RANGE = 90,
  localparam int unsigned BW     = (BIT_WIDTH > 0) ? BIT_WIDTH : 1,
  localparam int unsigned IH_L   = (IMAGE_HEIGHT > 0) ? IMAGE_HEIGHT : 1,
  localparam int unsigned IW_L   = (IMAGE_WIDTH > 0) ? IMAGE_WIDTH : 1,
  localparam int unsigned FH_L   = (FRAME_HEIGHT > 1) ? FRAME_HEIGHT : 2,
  localparam int unsigned FW_L   = (FRAME_WIDTH > 1) ? FRAME_WIDTH : 2,
  localparam int unsigned WR_L   = (WINDOW_RANGE < 0) ? 0 : ((WINDOW_RANGE > 100) ? 100 : WINDOW_RANGE),
  localparam int unsigned DRANGE = 1 << BW,
  localparam int unsigned V_BITW = $clog2(FH_L),
  localparam int unsigned H_BITW = $clog2(FW_L),
  localparam int unsigned TOTAL  = IH_L * IW_L,
  localparam int unsigned CLIP   = (TOTAL * (100 - WR_L)) / 200,
  localparam int unsigned CW     = $clog2(TOTAL + 1)
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic [BW-1:0]     in_pixel,
  input  logic [V_BITW-1:0] in_vcnt,
  input  logic [H_BITW-1:0] in_hcnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW-1:0]     out_bin,
  output logic [CW-1:0]     out_count,
  output logic              out_last,
  output logic [BW-1:0]     win_lo,
  output logic [BW-1:0]     win_hi,
  output logic              win_valid,
  output logic [7:0]        skip_count
);

  typedef enum logic [1:0] {S_INIT, S_WAIT, S_COUNT, S_DUMP} state_t;

  state_t state, state_next;

  logic          at_origin_c, in_active_c, at_last_c;
  logic          count_en_c, skip_c;
  logic          accept_c, load_c, issue_c;
  logic          we_c;
  logic [BW-1:0] wa_c, ra_c;
  logic [CW-1:0] wd_c, rd_val_c, cum_next_c;
  logic          lo_hit_c, hi_hit_c;

  logic [BW-1:0] init_ptr;
  logic          s1_vld;
  logic [BW-1:0] s1_addr;
  logic [CW-1:0] rd_q;
  logic          fwd_hit;
  logic [CW-1:0] fwd_data;
  logic [BW:0]   iss_cnt;
  logic          r_vld;
  logic [BW-1:0] r_bin;
  logic [CW-1:0] cum;
  logic          lo_found, hi_found;
  logic [BW-1:0] lo_cand, hi_cand;

  logic [CW-1:0] mem [DRANGE];

  // Raster position decode
  assign at_origin_c = (in_vcnt == '0) && (in_hcnt == '0);
  assign in_active_c = (32'(in_vcnt) < IH_L) && (32'(in_hcnt) < IW_L);
  assign at_last_c   = (32'(in_vcnt) == IH_L - 1) && (32'(in_hcnt) == IW_L - 1);

  // State register
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) state <= S_INIT;
    else        state <= state_next;
  end

  // Next-state and per-cycle strobes
  always_comb begin
    state_next = state;
    count_en_c = 1'b0;
    skip_c     = 1'b0;
    case (state)
      S_INIT:  if (init_ptr == '1) state_next = S_WAIT;
      S_WAIT:  if (at_origin_c) begin
                 count_en_c = in_active_c;
                 state_next = at_last_c ? S_DUMP : S_COUNT;
               end
      S_COUNT: begin
                 count_en_c = in_active_c;
                 if (at_last_c) state_next = S_DUMP;
               end
      S_DUMP:  begin
                 skip_c = at_origin_c;
                 if (accept_c && out_last) state_next = S_WAIT;
               end
      default: state_next = S_INIT;
    endcase
  end

  // RAM port control: a read issued on edge e is usable in the following cycle;
  // a write landing on the same edge as a read to the same bin is forwarded.
  always_comb begin
    accept_c = out_valid && out_ready;
    load_c   = r_vld && (!out_valid || out_ready);
    issue_c  = (state == S_DUMP) && !iss_cnt[BW] && (!r_vld || load_c);
    rd_val_c = fwd_hit ? fwd_data : rd_q;

    // A stalled prefetch keeps re-reading its own bin so rd_q stays current
    ra_c = in_pixel;
    if (state == S_DUMP) ra_c = issue_c ? iss_cnt[BW-1:0] : r_bin;

    we_c = 1'b0;
    wa_c = s1_addr;
    wd_c = rd_val_c + CW'(1);
    if (state == S_INIT) begin
      we_c = 1'b1;
      wa_c = init_ptr;
      wd_c = '0;
    end else if (s1_vld) begin
      we_c = 1'b1;
    end else if (accept_c) begin
      we_c = 1'b1;
      wa_c = out_bin;
      wd_c = '0;
    end

    cum_next_c = cum + out_count;
    lo_hit_c   = !lo_found && (cum_next_c > CW'(CLIP));
    hi_hit_c   = !hi_found && (cum_next_c >= CW'(TOTAL - CLIP));
  end

  // Histogram RAM (no reset; cleared by INIT)
  always_ff @(posedge clock) begin
    if (we_c) mem[wa_c] <= wd_c;
    rd_q <= mem[ra_c];
  end

  // Counting pipeline, dump stream, window tracking
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      init_ptr   <= '0;
      s1_vld     <= 1'b0;
      s1_addr    <= '0;
      fwd_hit    <= 1'b0;
      fwd_data   <= '0;
      iss_cnt    <= '0;
      r_vld      <= 1'b0;
      r_bin      <= '0;
      out_valid  <= 1'b0;
      out_bin    <= '0;
      out_count  <= '0;
      out_last   <= 1'b0;
      cum        <= '0;
      lo_found   <= 1'b0;
      hi_found   <= 1'b0;
      lo_cand    <= '0;
      hi_cand    <= '0;
      win_lo     <= '0;
      win_hi     <= '0;
      win_valid  <= 1'b0;
      skip_count <= '0;
    end else begin
      init_ptr <= (state == S_INIT) ? init_ptr + BW'(1) : '0;
      s1_vld   <= count_en_c;
      s1_addr  <= in_pixel;
      fwd_hit  <= we_c && (wa_c == ra_c);
      fwd_data <= wd_c;

      if (state != S_DUMP) iss_cnt <= '0;
      else if (issue_c)    iss_cnt <= iss_cnt + (BW+1)'(1);

      if (issue_c) begin
        r_vld <= 1'b1;
        r_bin <= iss_cnt[BW-1:0];
      end else if (load_c) begin
        r_vld <= 1'b0;
      end

      if (load_c) begin
        out_valid <= 1'b1;
        out_bin   <= r_bin;
        out_count <= rd_val_c;
        out_last  <= (r_bin == '1);
      end else if (accept_c) begin
        out_valid <= 1'b0;
      end

      win_valid <= 1'b0;
      if (accept_c) begin
        if (out_last) begin
          // N(last) is TOTAL, so any bound not yet found is the last bin
          win_lo    <= lo_hit_c ? out_bin : lo_cand;
          win_hi    <= hi_hit_c ? out_bin : hi_cand;
          win_valid <= 1'b1;
          cum       <= '0;
          lo_found  <= 1'b0;
          hi_found  <= 1'b0;
        end else begin
          cum <= cum_next_c;
          if (lo_hit_c) begin
            lo_found <= 1'b1;
            lo_cand  <= out_bin;
          end
          if (hi_hit_c) begin
            hi_found <= 1'b1;
            hi_cand  <= out_bin;
          end
        end
      end

      if (skip_c && (skip_count != 8'hFF)) skip_count <= skip_count + 8'd1;
    end
  end

endmodule
